// File: rtl/seq_det_pkg.sv
// Shared types and defaults for the serial pattern-detector controller.
//   state_e    : controller FSM state encoding (2-bit)
//   DEF_*      : default widths for data word, pattern and match counter
package seq_det_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_PAT_W  = 5;
  localparam int unsigned DEF_CNT_W  = 5;

endpackage

// File: rtl/seq_win_det.sv
// Windowed Moore pattern detector fed one bit per cycle.
//   clk, rst    : clock, asynchronous active-high reset
//   clr         : synchronous clear of window, bit history and det_out
//   bit_valid   : bit_in is presented this cycle
//   bit_in      : serial bit, first bit in time ends up in pattern MSB
//   pattern     : pattern to match against the window
//   overlap     : 1 = overlapping matches, 0 = restart history after a match
//   det_out     : registered match flag (high the cycle after the last pattern bit)
module seq_win_det
  import seq_det_pkg::*;
#(
  parameter int unsigned PAT_W = DEF_PAT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             bit_valid,
  input  logic             bit_in,
  input  logic [PAT_W-1:0] pattern,
  input  logic             overlap,
  output logic             det_out
);

  localparam int unsigned SEEN_W = $clog2(PAT_W + 1);
  localparam logic [SEEN_W-1:0] SEEN_MAX = SEEN_W'(PAT_W);

  logic [PAT_W-1:0]  win_q, win_d, win_next;
  logic [SEEN_W-1:0] seen_q, seen_d, seen_inc;
  logic              det_q, det_d;
  logic              hit;

  always_comb begin
    win_next = {win_q[PAT_W-2:0], bit_in};
    seen_inc = (seen_q == SEEN_MAX) ? seen_q : seen_q + SEEN_W'(1);
    // seen saturates at PAT_W, so equality means the whole window is valid history
    hit      = (win_next == pattern) && (seen_inc == SEEN_MAX);
    win_d    = win_q;
    seen_d   = seen_q;
    det_d    = 1'b0;
    if (clr) begin
      win_d  = '0;
      seen_d = '0;
    end else if (bit_valid) begin
      win_d  = win_next;
      // Non-overlapping: forget history so the next match needs PAT_W fresh bits
      seen_d = (hit && !overlap) ? '0 : seen_inc;
      det_d  = hit;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_q  <= '0;
      seen_q <= '0;
      det_q  <= 1'b0;
    end else begin
      win_q  <= win_d;
      seen_q <= seen_d;
      det_q  <= det_d;
    end
  end

  assign det_out = det_q;

endmodule

// File: rtl/seq_det_ctrl.sv
// Controller that serialises a parallel word MSB-first into a windowed Moore
// detector, counts matches and reports the count with a one-cycle done pulse.
//   clk, rst               : clock, asynchronous active-high reset
//   cfg_pattern/overlap    : job configuration, sampled at accept
//   in_valid/in_ready/data : word handshake (ready only in IDLE)
//   ser_bit/ser_valid      : bit presented to the detector (SHIFT only)
//   det_out                : registered detector output
//   match_cnt              : saturating match count, final during done
//   busy                   : SHIFT or FLUSH
//   done                   : one-cycle completion pulse
module seq_det_ctrl
  import seq_det_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned PAT_W  = DEF_PAT_W,
  parameter int unsigned CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PAT_W-1:0]  cfg_pattern,
  input  logic              cfg_overlap,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              ser_bit,
  output logic              ser_valid,
  output logic              det_out,
  output logic [CNT_W-1:0]  match_cnt,
  output logic              busy,
  output logic              done
);

  localparam int unsigned BIT_CNT_W = $clog2(DATA_W + 1);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_W - 1);

  state_e               state_q, state_d;
  logic [DATA_W-1:0]    shift_q, shift_d;
  logic [PAT_W-1:0]     pat_q, pat_d;
  logic                 ovl_q, ovl_d;
  logic [BIT_CNT_W-1:0] bits_q, bits_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 det_clr;
  logic                 accept;

  assign in_ready  = (state_q == ST_IDLE) && !rst;
  assign accept    = in_valid && in_ready;
  assign ser_valid = (state_q == ST_SHIFT);
  assign ser_bit   = ser_valid & shift_q[DATA_W-1];
  assign busy      = (state_q == ST_SHIFT) || (state_q == ST_FLUSH);
  assign done      = (state_q == ST_DONE);
  assign match_cnt = cnt_q;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    pat_d   = pat_q;
    ovl_d   = ovl_q;
    bits_d  = bits_q;
    cnt_d   = cnt_q;
    det_clr = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          shift_d = in_data;
          pat_d   = cfg_pattern;
          ovl_d   = cfg_overlap;
          bits_d  = '0;
          cnt_d   = '0;
          det_clr = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        shift_d = {shift_q[DATA_W-2:0], 1'b0};
        bits_d  = bits_q + BIT_CNT_W'(1);
        if (bits_q == LAST_BIT) state_d = ST_FLUSH;
      end
      // One extra cycle so a match on the final bit still reaches the counter
      ST_FLUSH: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    if (busy && det_out && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      pat_q   <= '0;
      ovl_q   <= 1'b0;
      bits_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      pat_q   <= pat_d;
      ovl_q   <= ovl_d;
      bits_q  <= bits_d;
      cnt_q   <= cnt_d;
    end
  end

  seq_win_det #(
    .PAT_W (PAT_W)
  ) u_win_det (
    .clk       (clk),
    .rst       (rst),
    .clr       (det_clr),
    .bit_valid (ser_valid),
    .bit_in    (ser_bit),
    .pattern   (pat_q),
    .overlap   (ovl_q),
    .det_out   (det_out)
  );

endmodule

// File: tb/tb_seq_det_ctrl.sv
module tb_seq_det_ctrl;

  localparam int DATA_W = 16;
  localparam int PAT_W  = 5;
  localparam int CNT_W  = 5;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int K_DONE = DATA_W + 2;  // cycle of the done pulse after accept
  localparam int K_IDLE = DATA_W + 3;  // back in idle

  logic              clk = 1'b0;
  logic              rst;
  logic [PAT_W-1:0]  cfg_pattern;
  logic              cfg_overlap;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              ser_bit;
  logic              ser_valid;
  logic              det_out;
  logic [CNT_W-1:0]  match_cnt;
  logic              busy;
  logic              done;

  seq_det_ctrl #(
    .DATA_W (DATA_W),
    .PAT_W  (PAT_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_pattern (cfg_pattern),
    .cfg_overlap (cfg_overlap),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .ser_bit     (ser_bit),
    .ser_valid   (ser_valid),
    .det_out     (det_out),
    .match_cnt   (match_cnt),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // k = cycles since accept (0 = idle since reset, K_IDLE = idle after a job)
  int k = 0;
  int cyc = 0;
  bit job_bits [0:31];  // job_bits[i] = i-th serial bit (1-based)
  bit exp_det  [0:31];  // exp_det[c]  = det_out expected in cycle c after accept

  task automatic build_job(input logic [DATA_W-1:0] w, input logic [PAT_W-1:0] p,
                           input logic ovl);
    int last;
    bit m;
    for (int i = 0; i < 32; i++) begin
      job_bits[i] = 1'b0;
      exp_det[i]  = 1'b0;
    end
    for (int i = 1; i <= DATA_W; i++) job_bits[i] = w[DATA_W-i];
    last = 0;  // index of last bit consumed by a non-overlapping match
    for (int i = PAT_W; i <= DATA_W; i++) begin
      m = (i - last >= PAT_W);
      for (int j = 0; j < PAT_W; j++)
        if (job_bits[i-PAT_W+1+j] != p[PAT_W-1-j]) m = 1'b0;
      if (m) begin
        exp_det[i+1] = 1'b1;  // Moore: one cycle after the final bit
        if (!ovl) last = i;
      end
    end
  endtask

  function automatic int exp_cnt(input int kk);
    int s = 0;
    for (int j = 1; j < kk && j <= DATA_W + 1; j++) s += int'(exp_det[j]);
    return (s > CNT_MAX) ? CNT_MAX : s;
  endfunction

  // observations for the directed literal checks
  logic [31:0] det_mask;
  int          done_k;
  int          done_cnt;
  bit          done_seen;
  int          dut_acc[$];

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      k = 0;
      chk("rst_busy", busy, 0);
      chk("rst_ser_valid", ser_valid, 0);
      chk("rst_ser_bit", ser_bit, 0);
      chk("rst_det_out", det_out, 0);
      chk("rst_match_cnt", match_cnt, 0);
      chk("rst_done", done, 0);
    end else begin
      chk("in_ready", in_ready, (k == 0 || k == K_IDLE));
      chk("busy", busy, (k >= 1 && k <= DATA_W + 1));
      chk("ser_valid", ser_valid, (k >= 1 && k <= DATA_W));
      chk("ser_bit", ser_bit, (k >= 1 && k <= DATA_W) ? job_bits[k] : 1'b0);
      chk("det_out", det_out, (k >= 1 && k <= K_DONE) ? exp_det[k] : 1'b0);
      chk("match_cnt", match_cnt, exp_cnt(k));
      chk("done", done, (k == K_DONE));
      if (det_out) det_mask = det_mask | (32'd1 << k);
      if (done) begin
        done_seen = 1'b1;
        done_k    = k;
        done_cnt  = int'(match_cnt);
      end
      if (in_ready && in_valid) dut_acc.push_back(cyc);
      // advance to the state seen after the coming rising edge
      if ((k == 0 || k == K_IDLE) && in_valid) begin
        build_job(in_data, cfg_pattern, cfg_overlap);
        k = 1;
      end else if (k >= 1 && k < K_IDLE) begin
        k++;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic clear_obs();
    det_mask  = '0;
    done_seen = 1'b0;
    done_k    = -1;
    done_cnt  = -1;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done_seen && n < 40) begin
      @(posedge clk);
      n++;
    end
    chk("done_seen", done_seen, 1);
  endtask

  task automatic run_job(input string name, input logic [DATA_W-1:0] w,
                         input logic [PAT_W-1:0] p, input logic ovl,
                         input int exp_c, input logic [31:0] exp_mask);
    @(posedge clk);
    #1;
    clear_obs();
    in_data     = w;
    cfg_pattern = p;
    cfg_overlap = ovl;
    in_valid    = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_done();
    chk({name, "_done_cycle"}, done_k, K_DONE);
    chk({name, "_count"}, done_cnt, exp_c);
    chk({name, "_det_cycles"}, det_mask, exp_mask);
    @(posedge clk);
  endtask

  initial begin
    logic [19:0] rep;
    rst         = 1'b1;
    in_valid    = 1'b0;
    in_data     = '0;
    cfg_pattern = '0;
    cfg_overlap = 1'b0;
    clear_obs();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_match_cnt", match_cnt, 0);
    chk("reset_busy", busy, 0);

    run_job("ovl_b6c0", 16'hB6C0, 5'b10110, 1'b1, 3, 32'h0000_1240);
    run_job("novl_b6c0", 16'hB6C0, 5'b10110, 1'b0, 2, 32'h0000_1040);
    run_job("ovl_ffff", 16'hFFFF, 5'b11111, 1'b1, 12, 32'h0003_FFC0);
    run_job("novl_ffff", 16'hFFFF, 5'b11111, 1'b0, 3, 32'h0001_0840);
    run_job("zero_word", 16'h0000, 5'b10110, 1'b1, 0, 32'h0);

    // Back-to-back: in_valid held, cfg/data changed right after the first accept
    @(posedge clk);
    #1;
    clear_obs();
    dut_acc.delete();
    in_data     = 16'hB6C0;
    cfg_pattern = 5'b10110;
    cfg_overlap = 1'b1;
    in_valid    = 1'b1;
    @(posedge clk);
    #1;
    in_data     = 16'hFFFF;
    cfg_pattern = 5'b11111;
    cfg_overlap = 1'b0;
    wait_done();
    chk("b2b_first_count", done_cnt, 3);
    clear_obs();
    @(posedge clk);
    #1;
    wait_done();
    chk("b2b_second_count", done_cnt, 3);
    in_valid = 1'b0;
    chk("b2b_accepts", dut_acc.size() >= 2, 1);
    if (dut_acc.size() >= 2) chk("b2b_spacing", dut_acc[1] - dut_acc[0], 19);
    repeat (2) @(posedge clk);

    // Asynchronous reset in cycle 8 of a job
    @(posedge clk);
    #1;
    clear_obs();
    in_data     = 16'hB6C0;
    cfg_pattern = 5'b10110;
    cfg_overlap = 1'b1;
    in_valid    = 1'b1;
    @(posedge clk);  // accept edge
    #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);  // now in cycle 8
    #1;
    chk("pre_rst_cnt", match_cnt, 1);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_ser_valid", ser_valid, 0);
    chk("arst_match_cnt", match_cnt, 0);
    chk("arst_det_out", det_out, 0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_in_ready", in_ready, 1);
    repeat (20) @(posedge clk);
    chk("arst_no_done", done_seen, 0);
    run_job("after_rst", 16'hB6C0, 5'b10110, 1'b0, 2, 32'h0000_1040);

    // Randomized traffic: cfg/data churn every cycle, occasional resets
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk);
      #1;
      rst         = ($urandom_range(0, 299) == 0);
      in_valid    = ($urandom_range(0, 2) != 0);
      cfg_pattern = PAT_W'($urandom);
      cfg_overlap = $urandom_range(0, 1) == 1;
      rep         = {4{cfg_pattern}};
      in_data     = ($urandom_range(0, 3) == 0) ? rep[19:4] : DATA_W'($urandom);
      if ($urandom_range(0, 9) == 0) in_data = '1;
    end
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    repeat (25) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
